patch_trigger_unit: RTL and testbench
=====================================

# patch_trigger_unit

Programmable trigger-and-override stage that consumes the observe-tapped bits exported by an instrumented design block and drives that block's control-tapped signals. A two-event sequence (pattern A, then N occurrences of pattern B) on the observe vector fires a patch. While the patch is active, the selected control signals are overridden with a programmed value for a programmed number of cycles. Configuration arrives as a serial bitstream, so one patch fabric can be reprogrammed after tape-out.

## Interface
- OBS_W, 8: width of observe vector (concatenated observe taps)
- CTRL_W, 4: width of control vector (concatenated control taps)
- CNT_W, 8: width of occurrence-threshold and hold-length fields
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_en  in  1  configuration shift enable; while high, unit is disarmed
- cfg_bit  in  1  serial config data, MSB-first, one bit per cycle when cfg_en=1
- obs  in  OBS_W  observe taps from instrumented block
- ctrl_in  in  CTRL_W  original (unpatched) control signals
- ctrl_out  out  CTRL_W  control signals delivered to instrumented block
- fired  out  1  high while override active (state FIRE)
- armed  out  1  high in ARM_A or ARM_B

## Operation
- Config register CFG_W = 4*OBS_W + 2*CNT_W + CTRL_W (52 at defaults). When cfg_en=1: cfg_reg <= {cfg_reg[CFG_W-2:0], cfg_bit}.
- Field order, MSB to LSB: mask_a, val_a, mask_b, val_b, thresh, hold, ctrl_val.
- Match: hit_x = ((obs & mask_x) == (val_x & mask_x)). mask_x=0 means always hit.
- FSM states: IDLE, ARM_A, ARM_B, FIRE.
  - IDLE: entered on reset or whenever cfg_en=1, from any state. When cfg_en=0, goes to ARM_A next cycle.
  - ARM_A: on hit_a, clear cnt and go to ARM_B.
  - ARM_B: on hit_b, cnt <= cnt+1. When cnt+1 >= eff_thresh, load hold_cnt=hold and go to FIRE. eff_thresh = (thresh==0) ? 1 : thresh. A hit_a in ARM_B is ignored.
  - FIRE: each cycle hold_cnt decrements; at hold_cnt==1, go to ARM_A. hold==0 means hold until cfg_en.
- ctrl_out = (state==FIRE) ? ctrl_val : ctrl_in. Purely combinational mux on registered state.
- cnt and hold_cnt are CNT_W wide unsigned. cnt cannot wrap because the transition happens at threshold.
- Reset values: state=IDLE, cfg_reg=0, cnt=0, hold_cnt=0. After reset: fired=0, armed=0, ctrl_out=ctrl_in.

## Timing
- obs is sampled combinationally in the cycle of the hit. The state change is visible on the next edge.
- Latency: the edge after the threshold-reaching hit_b sets fired=1, and ctrl_out switches in that same cycle.
- Override lasts exactly `hold` cycles of fired=1.
- A hit_b in the same cycle as the ARM_A->ARM_B transition is not counted; counting starts the next cycle.
- cfg_en asserted mid-FIRE: fired drops and ctrl_out returns to ctrl_in on the next edge. cfg_reg shifts that same edge.
- Async reset mid-FIRE: ctrl_out = ctrl_in immediately, no clock required.
- Reloading takes CFG_W cycles. Fields are live and unstable during shifting, which is harmless because the FSM is in IDLE.

## Structure
- Package patch_pkg holds:
  - the state enum
  - localparam CFG_W
  - field offset/width localparams derived from OBS_W/CTRL_W/CNT_W
- Sub-module patch_obs_match (obs, mask, val -> hit), instantiated twice (A, B).
- The top level contains the shift register, FSM, counters, and output mux.

## Test plan
- Reset with ctrl_in=4'hA -> ctrl_out=4'hA, fired=0, armed=0 before any clock edge.
- Shift config mask_a=8'hFF, val_a=8'h3C, mask_b=8'h01, val_b=8'h01, thresh=3, hold=2, ctrl_val=4'h5. Drive obs=8'h3C, then 8'h01 on three cycles -> fired=1 for exactly 2 cycles with ctrl_out=4'h5, then armed=1 and ctrl_out=ctrl_in.
- Same config with hit_b on non-consecutive cycles (gaps of obs=8'h00) -> still fires after the third hit_b.
- thresh=0, hold=1 -> fires on the edge after the first hit_b, 1-cycle override.
- hold=0 during FIRE: stays fired for 100 cycles; then raise cfg_en -> fired=0 and ctrl_out=ctrl_in next edge.
- Assert rst_n=0 asynchronously mid-FIRE -> ctrl_out follows ctrl_in in the same cycle. After release: state IDLE, cfg_reg=0. With cfg_reg=0 (mask_a=mask_b=0, so every cycle hits), the unit then cycles IDLE -> ARM_A -> ARM_B -> FIRE driving ctrl_val=0 and holding until cfg_en.

Source files
------------

// File: rtl/patch_pkg.sv
// Shared types and configuration-word layout for the patch trigger unit.
// All widths live here so the shift register, field slicing and matchers agree.
package patch_pkg;

  localparam int OBS_W  = 8;
  localparam int CTRL_W = 4;
  localparam int CNT_W  = 8;

  localparam int CFG_W = 4 * OBS_W + 2 * CNT_W + CTRL_W;

  // Field LSB positions inside the config word, MSB-first order:
  // mask_a, val_a, mask_b, val_b, thresh, hold, ctrl_val.
  localparam int CTRL_VAL_LSB = 0;
  localparam int HOLD_LSB     = CTRL_VAL_LSB + CTRL_W;
  localparam int THRESH_LSB   = HOLD_LSB + CNT_W;
  localparam int VAL_B_LSB    = THRESH_LSB + CNT_W;
  localparam int MASK_B_LSB   = VAL_B_LSB + OBS_W;
  localparam int VAL_A_LSB    = MASK_B_LSB + OBS_W;
  localparam int MASK_A_LSB   = VAL_A_LSB + OBS_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM_A = 2'd1,
    ST_ARM_B = 2'd2,
    ST_FIRE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [OBS_W-1:0]  mask_a;
    logic [OBS_W-1:0]  val_a;
    logic [OBS_W-1:0]  mask_b;
    logic [OBS_W-1:0]  val_b;
    logic [CNT_W-1:0]  thresh;
    logic [CNT_W-1:0]  hold;
    logic [CTRL_W-1:0] ctrl_val;
  } cfg_t;

endpackage

// File: rtl/patch_obs_match.sv
// Masked equality compare of the observe vector; a zero mask always hits.
module patch_obs_match
  import patch_pkg::*;
(
  input  logic [OBS_W-1:0] obs,
  input  logic [OBS_W-1:0] mask,
  input  logic [OBS_W-1:0] val,
  output logic             hit
);

  assign hit = ((obs & mask) == (val & mask));

endmodule

// File: rtl/patch_trigger_unit.sv
// Trigger-and-override stage: serial config, A-then-N*B trigger FSM and a
// control-tap override mux driven from registered state.
module patch_trigger_unit
  import patch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en,
  input  logic              cfg_bit,
  input  logic [OBS_W-1:0]  obs,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              fired,
  output logic              armed
);

  logic [CFG_W-1:0] cfg_q, cfg_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  cfg_t             cfg;
  logic             hit_a, hit_b;
  logic [CNT_W-1:0] eff_thresh;
  logic [CNT_W:0]   cnt_inc;

  assign cfg = cfg_t'(cfg_q);

  patch_obs_match u_match_a (
    .obs  (obs),
    .mask (cfg.mask_a),
    .val  (cfg.val_a),
    .hit  (hit_a)
  );

  patch_obs_match u_match_b (
    .obs  (obs),
    .mask (cfg.mask_b),
    .val  (cfg.val_b),
    .hit  (hit_b)
  );

  assign eff_thresh = (cfg.thresh == '0) ? CNT_W'(1) : cfg.thresh;
  // One extra bit so the compare is exact even at thresh = 2**CNT_W-1.
  assign cnt_inc    = {1'b0, cnt_q} + (CNT_W+1)'(1);

  always_comb begin
    cfg_d = cfg_q;
    if (cfg_en) cfg_d = {cfg_q[CFG_W-2:0], cfg_bit};
  end

  // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_cnt_d = hold_cnt_q;
    if (cfg_en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ARM_A;
        ST_ARM_A: begin
          if (hit_a) begin
            cnt_d   = '0;
            state_d = ST_ARM_B;
          end
        end
        ST_ARM_B: begin
          if (hit_b) begin
            cnt_d = cnt_inc[CNT_W-1:0];
            if (cnt_inc >= {1'b0, eff_thresh}) begin
              hold_cnt_d = cfg.hold;
              state_d    = ST_FIRE;
            end
          end
        end
        ST_FIRE: begin
          // hold_cnt of zero never reaches 1, so the override stays until cfg_en.
          if (hold_cnt_q == CNT_W'(1)) begin
            hold_cnt_d = '0;
            state_d    = ST_ARM_A;
          end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q      <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      cfg_q      <= cfg_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign fired    = (state_q == ST_FIRE);
  assign armed    = (state_q == ST_ARM_A) || (state_q == ST_ARM_B);
  assign ctrl_out = fired ? cfg.ctrl_val : ctrl_in;

endmodule

// File: tb/tb_patch_trigger_unit.sv
// Directed, table-driven bench for patch_trigger_unit with hand-computed expectations.
module tb_patch_trigger_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_en;
  logic       cfg_bit;
  logic [7:0] obs;
  logic [3:0] ctrl_in;
  logic [3:0] ctrl_out;
  logic       fired;
  logic       armed;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       cfg_en;
    logic [7:0] obs;
    logic [3:0] ctrl_in;
    logic       exp_fired;
    logic       exp_armed;
    logic [3:0] exp_ctrl;
  } vec_t;

  vec_t vecs[$];

  patch_trigger_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_en   (cfg_en),
    .cfg_bit  (cfg_bit),
    .obs      (obs),
    .ctrl_in  (ctrl_in),
    .ctrl_out (ctrl_out),
    .fired    (fired),
    .armed    (armed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic f, input logic a, input logic [3:0] c);
    check({tag, ".fired"}, 32'(fired), 32'(f));
    check({tag, ".armed"}, 32'(armed), 32'(a));
    check({tag, ".ctrl_out"}, 32'(ctrl_out), 32'(c));
  endtask

  function automatic logic [51:0] make_cfg(input logic [7:0] ma, input logic [7:0] va,
                                           input logic [7:0] mb, input logic [7:0] vb,
                                           input logic [7:0] th, input logic [7:0] hd,
                                           input logic [3:0] cv);
    return {ma, va, mb, vb, th, hd, cv};
  endfunction

  // Shift a full word MSB-first; leaves cfg_en high so the FSM stays in IDLE.
  task automatic shift_cfg(input logic [51:0] word);
    for (int i = 51; i >= 0; i--) begin
      cfg_en  = 1'b1;
      cfg_bit = word[i];
      @(posedge clk);
      #1;
    end
    cfg_bit = 1'b0;
    check_outs("after_shift", 1'b0, 1'b0, ctrl_in);
  endtask

  task automatic add(input logic e, input logic [7:0] o, input logic [3:0] ci,
                     input logic f, input logic a, input logic [3:0] c);
    vec_t v;
    v.cfg_en = e; v.obs = o; v.ctrl_in = ci;
    v.exp_fired = f; v.exp_armed = a; v.exp_ctrl = c;
    vecs.push_back(v);
  endtask

  // Each vector: drive inputs, take one edge, compare the post-edge outputs.
  task automatic run_vecs(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      cfg_en  = vecs[k].cfg_en;
      obs     = vecs[k].obs;
      ctrl_in = vecs[k].ctrl_in;
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", k), vecs[k].exp_fired, vecs[k].exp_armed, vecs[k].exp_ctrl);
    end
  endtask

  initial begin
    // Phase 1 (idx 0-14): A=3C exact, B=bit0, thresh 3, hold 2, ctrl_val 5.
    add(0, 8'h00, 4'hA, 0, 1, 4'hA); // IDLE -> ARM_A
    add(0, 8'h3C, 4'hA, 0, 1, 4'hA); // -> ARM_B
    add(0, 8'h01, 4'hA, 0, 1, 4'hA); // cnt 1
    add(0, 8'h01, 4'hA, 0, 1, 4'hA); // cnt 2
    add(0, 8'h01, 4'hA, 1, 0, 4'h5); // cnt 3 -> FIRE
    add(0, 8'h00, 4'hA, 1, 0, 4'h5); // hold 2 -> 1
    add(0, 8'h00, 4'hA, 0, 1, 4'hA); // -> ARM_A
    add(0, 8'h3C, 4'h3, 0, 1, 4'h3); // -> ARM_B
    add(0, 8'h01, 4'h3, 0, 1, 4'h3); // cnt 1
    add(0, 8'h00, 4'h3, 0, 1, 4'h3); // gap
    add(0, 8'h01, 4'h3, 0, 1, 4'h3); // cnt 2
    add(0, 8'h3C, 4'h3, 0, 1, 4'h3); // hit_a ignored in ARM_B
    add(0, 8'h01, 4'h3, 1, 0, 4'h5); // cnt 3 -> FIRE
    add(0, 8'h00, 4'h3, 1, 0, 4'h5);
    add(0, 8'h00, 4'h3, 0, 1, 4'h3); // -> ARM_A
    // Phase 2 (idx 15-22): A always hits, B=bit0, thresh 0, hold 1, ctrl_val 9.
    add(0, 8'h01, 4'hA, 0, 1, 4'hA); // -> ARM_A
    add(0, 8'h01, 4'hA, 0, 1, 4'hA); // -> ARM_B; hit_b here not counted
    add(0, 8'h00, 4'hA, 0, 1, 4'hA); // no hit_b, still ARM_B
    add(0, 8'h01, 4'hA, 1, 0, 4'h9); // first hit_b -> FIRE
    add(0, 8'h01, 4'hA, 0, 1, 4'hA); // 1-cycle override over
    add(0, 8'h01, 4'hA, 0, 1, 4'hA); // -> ARM_B
    add(0, 8'h01, 4'hA, 1, 0, 4'h9); // -> FIRE
    add(0, 8'h00, 4'h2, 0, 1, 4'h2); // -> ARM_A
    // Phase 3 (idx 23-25): everything hits, thresh 1, hold 0, ctrl_val 6.
    add(0, 8'h00, 4'hA, 0, 1, 4'hA);
    add(0, 8'h00, 4'hA, 0, 1, 4'hA);
    add(0, 8'h00, 4'hA, 1, 0, 4'h6);
    // Phase 4 (idx 26-29): after reset, cfg is all zero so ctrl_val 0, hold forever.
    add(0, 8'h00, 4'hB, 0, 1, 4'hB);
    add(0, 8'h00, 4'hB, 0, 1, 4'hB);
    add(0, 8'h00, 4'hB, 1, 0, 4'h0);
    add(0, 8'h55, 4'hB, 1, 0, 4'h0);

    rst_n = 1'b0; cfg_en = 1'b1; cfg_bit = 1'b0; obs = 8'h00; ctrl_in = 4'hA;
    #1;
    check_outs("reset", 1'b0, 1'b0, 4'hA);
    #11;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    shift_cfg(make_cfg(8'hFF, 8'h3C, 8'h01, 8'h01, 8'd3, 8'd2, 4'h5));
    run_vecs(0, 14);

    shift_cfg(make_cfg(8'h00, 8'h00, 8'h01, 8'h01, 8'd0, 8'd1, 4'h9));
    run_vecs(15, 22);

    shift_cfg(make_cfg(8'h00, 8'h00, 8'h00, 8'h00, 8'd1, 8'd0, 4'h6));
    run_vecs(23, 25);
    for (int i = 0; i < 100; i++) begin
      ctrl_in = 4'(i);
      @(posedge clk);
      #1;
      check_outs("hold0", 1'b1, 1'b0, 4'h6);
    end
    ctrl_in = 4'hA;
    cfg_en  = 1'b1;
    @(posedge clk);
    #1;
    check_outs("cfg_en_exit", 1'b0, 1'b0, 4'hA);

    shift_cfg(make_cfg(8'h00, 8'h00, 8'h00, 8'h00, 8'd1, 8'd0, 4'h6));
    run_vecs(23, 25);
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    ctrl_in = 4'hB;
    #1;
    check_outs("async_reset", 1'b0, 1'b0, 4'hB);
    @(posedge clk);
    #1;
    check_outs("in_reset", 1'b0, 1'b0, 4'hB);
    #2;
    rst_n = 1'b1;
    run_vecs(26, 29);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
